config_frame_loader: RTL and testbench

- Clocked, parametrised successor to the transparent per-word config latch array.
- Accepts a configuration frame as a valid/ready word stream: NUM_WORDS payload words followed by one XOR checksum word.
- Payload is staged in a shadow store. The live configuration bus updates atomically, and only after the checksum passes.
- Sits between the fabric config port and the LUT-tile / routing config consumers. Also provides synchronous readback of the live configuration.

---
 rtl/config_frame_loader.sv | 124 ++++++++++++
 tb/tb_config_frame_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/config_frame_loader.sv
// Frame loader: stages NUM_WORDS config words plus an XOR checksum, commits them atomically to the live bus.
// Latency: the live bus updates one edge after checksum accept; readback is 1 cycle; backpressure is io_d_ready, high only in LOAD/CHECK.
module config_frame_loader #(
   parameter  int WORD_W    = 32,
   parameter  int NUM_WORDS = 45,
   localparam int CNT_W     = $clog2(NUM_WORDS + 1)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        io_start,
   input  logic                        io_abort,
   input  logic [WORD_W-1:0]           io_d_in,
   input  logic                        io_d_valid,
   output logic                        io_d_ready,
   output logic                        io_busy,
   output logic                        io_done,
   output logic                        io_err,
   input  logic [CNT_W-1:0]            io_rd_addr,
   output logic [WORD_W-1:0]           io_rd_data,
   output logic [WORD_W*NUM_WORDS-1:0] io_configs_out
);

   typedef enum logic [1:0] {IDLE, LOAD, CHECK, APPLY} state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [WORD_W-1:0]  csum_q, csum_d;
   logic               err_q, err_d;
   logic               done_q;
   logic [WORD_W-1:0]  rd_q;
   logic [WORD_W-1:0]  shadow_q [NUM_WORDS];
   logic [WORD_W-1:0]  live_q   [NUM_WORDS];
   logic               accept;
   logic               shadow_we;
   logic               commit;

   assign io_d_ready = (state_q == LOAD) || (state_q == CHECK);
   assign io_busy    = (state_q != IDLE);
   assign io_done    = done_q;
   assign io_err     = err_q;
   assign io_rd_data = rd_q;
   // Abort drops any word offered in the same cycle.
   assign accept     = io_d_valid && io_d_ready && !io_abort;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      csum_d    = csum_q;
      err_d     = err_q;
      shadow_we = 1'b0;
      commit    = 1'b0;
      if (io_abort) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (io_start) begin
                  state_d = LOAD;
                  cnt_d   = '0;
                  csum_d  = '0;
                  err_d   = 1'b0;
               end
            end
            LOAD: begin
               if (accept) begin
                  shadow_we = 1'b1;
                  csum_d    = csum_q ^ io_d_in;
                  cnt_d     = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_W'(NUM_WORDS - 1)) state_d = CHECK;
               end
            end
            CHECK: begin
               if (accept) begin
                  if (io_d_in == csum_q) begin
                     state_d = APPLY;
                  end else begin
                     err_d   = 1'b1;
                     state_d = IDLE;
                  end
               end
            end
            APPLY: begin
               commit  = 1'b1;
               state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         csum_q  <= '0;
         err_q   <= 1'b0;
         done_q  <= 1'b0;
         rd_q    <= '0;
         for (int i = 0; i < NUM_WORDS; i++) begin
            shadow_q[i] <= '0;
            live_q[i]   <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         csum_q  <= csum_d;
         err_q   <= err_d;
         done_q  <= commit;
         if (shadow_we) shadow_q[cnt_q] <= io_d_in;
         if (commit) begin
            for (int i = 0; i < NUM_WORDS; i++) live_q[i] <= shadow_q[i];
         end
         // Reads the pre-commit live word when it coincides with the commit edge.
         if (io_rd_addr < CNT_W'(NUM_WORDS)) rd_q <= live_q[io_rd_addr];
         else                                 rd_q <= '0;
      end
   end

   always_comb begin
      io_configs_out = '0;
      for (int i = 0; i < NUM_WORDS; i++) io_configs_out[WORD_W*i +: WORD_W] = live_q[i];
   end

endmodule

// File: tb/tb_config_frame_loader.sv
// Scoreboard bench for config_frame_loader: committed frames are queued when driven and compared on io_done.
module tb_config_frame_loader;
   localparam int WORD_W = 32;
   localparam int NW     = 45;
   localparam int CNT_W  = $clog2(NW + 1);
   localparam int BUS_W  = WORD_W * NW;

   logic              clk = 1'b0;
   logic              reset, io_start, io_abort, io_d_valid;
   logic [WORD_W-1:0] io_d_in;
   logic              io_d_ready, io_busy, io_done, io_err;
   logic [CNT_W-1:0]  io_rd_addr;
   logic [WORD_W-1:0] io_rd_data;
   logic [BUS_W-1:0]  io_configs_out;

   int n_cmp = 0;
   int n_bad = 0;
   logic [BUS_W-1:0] exp_q [$];
   logic [BUS_W-1:0] live_model;

   config_frame_loader #(.WORD_W(WORD_W), .NUM_WORDS(NW)) dut (
      .clk(clk), .reset(reset), .io_start(io_start), .io_abort(io_abort),
      .io_d_in(io_d_in), .io_d_valid(io_d_valid), .io_d_ready(io_d_ready),
      .io_busy(io_busy), .io_done(io_done), .io_err(io_err),
      .io_rd_addr(io_rd_addr), .io_rd_data(io_rd_data),
      .io_configs_out(io_configs_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [BUS_W-1:0] frame_bus(input logic [WORD_W-1:0] base);
      logic [BUS_W-1:0] b;
      for (int i = 0; i < NW; i++) b[WORD_W*i +: WORD_W] = base + WORD_W'(i);
      return b;
   endfunction

   function automatic logic [WORD_W-1:0] frame_csum(input logic [WORD_W-1:0] base);
      logic [WORD_W-1:0] c = '0;
      for (int i = 0; i < NW; i++) c ^= base + WORD_W'(i);
      return c;
   endfunction

   task automatic send_word(input logic [WORD_W-1:0] w, input bit stall);
      bit acc;
      int guard;
      if (stall) begin
         guard = 0;
         while ($urandom_range(0, 1) == 1 && guard < 8) begin
            io_d_valid = 1'b0;
            tick();
            guard++;
         end
      end
      io_d_valid = 1'b1;
      io_d_in    = w;
      guard      = 0;
      do begin
         acc = io_d_ready;
         tick();
         guard++;
      end while (!acc && guard < 200);
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic start_frame();
      io_start = 1'b1;
      tick();
      io_start = 1'b0;
   endtask

   task automatic load_words(input logic [WORD_W-1:0] base, input int n, input bit stall);
      for (int i = 0; i < n; i++) send_word(base + WORD_W'(i), stall);
      io_d_valid = 1'b0;
   endtask

   // Monitor: every commit must match the oldest queued frame.
   always @(negedge clk) begin
      if (io_done) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            logic [BUS_W-1:0] e;
            e = exp_q.pop_front();
            for (int i = 0; i < NW; i++)
               chk($sformatf("commit_w%0d", i), io_configs_out[WORD_W*i +: WORD_W], e[WORD_W*i +: WORD_W]);
         end
      end
   end

   initial begin
      reset = 1'b1; io_start = 1'b0; io_abort = 1'b0; io_d_valid = 1'b0;
      io_d_in = '0; io_rd_addr = '0; live_model = '0;
      tick(); tick(); tick();
      chk("rst_busy", io_busy, 0);
      chk("rst_ready", io_d_ready, 0);
      chk("rst_done", io_done, 0);
      chk("rst_err", io_err, 0);
      chk("rst_rd", io_rd_data, 0);
      chk("rst_live44", io_configs_out[WORD_W*44 +: WORD_W], 0);
      reset = 1'b0;
      tick();

      // Bad checksum: error, no commit, live bus stays at reset value.
      start_frame();
      chk("load_ready", io_d_ready, 1);
      load_words(32'h1000_0000, NW, 1'b0);
      send_word(32'h1000_002D, 1'b0);
      io_d_valid = 1'b0;
      chk("bad_err", io_err, 1);
      chk("bad_busy", io_busy, 0);
      tick();
      chk("bad_no_done", io_done, 0);
      chk("bad_live0", io_configs_out[0 +: WORD_W], live_model[0 +: WORD_W]);
      chk("bad_live44", io_configs_out[WORD_W*44 +: WORD_W], live_model[WORD_W*44 +: WORD_W]);

      // Nominal frame with a stray start in LOAD after word 10.
      start_frame();
      chk("err_cleared", io_err, 0);
      load_words(32'h1000_0000, 11, 1'b0);
      io_start = 1'b1;
      tick();
      io_start = 1'b0;
      chk("start_in_load_busy", io_busy, 1);
      for (int i = 11; i < NW; i++) send_word(32'h1000_0000 + WORD_W'(i), 1'b0);
      live_model = frame_bus(32'h1000_0000);
      exp_q.push_back(live_model);
      send_word(32'h1000_002C, 1'b0);
      io_d_valid = 1'b0;
      chk("nom_done_T", io_done, 0);
      tick();
      chk("nom_done_T1", io_done, 1);
      chk("nom_err", io_err, 0);
      chk("nom_live44", io_configs_out[WORD_W*44 +: WORD_W], 32'h1000_002C);
      tick();
      chk("nom_done_off", io_done, 0);
      chk("nom_busy", io_busy, 0);

      // Readback, including out-of-range address.
      io_rd_addr = 6'd0;  tick(); chk("rd_0", io_rd_data, 32'h1000_0000);
      io_rd_addr = 6'd44; tick(); chk("rd_44", io_rd_data, 32'h1000_002C);
      io_rd_addr = 6'd45; tick(); chk("rd_45", io_rd_data, 0);

      // Random stalls must not drop or duplicate words.
      start_frame();
      load_words(32'h1000_0000, NW, 1'b1);
      exp_q.push_back(frame_bus(32'h1000_0000));
      send_word(frame_csum(32'h1000_0000), 1'b1);
      io_d_valid = 1'b0;
      tick(); tick();
      chk("stall_busy", io_busy, 0);

      // Abort after word 20 with a word offered in the abort cycle.
      start_frame();
      load_words(32'h1500_0000, 21, 1'b0);
      io_abort = 1'b1; io_d_valid = 1'b1; io_d_in = 32'hDEAD_BEEF;
      tick();
      io_abort = 1'b0; io_d_valid = 1'b0;
      chk("abort_busy", io_busy, 0);
      chk("abort_ready", io_d_ready, 0);
      chk("abort_live0", io_configs_out[0 +: WORD_W], live_model[0 +: WORD_W]);
      chk("abort_live20", io_configs_out[WORD_W*20 +: WORD_W], live_model[WORD_W*20 +: WORD_W]);

      // Full frame after abort; read coinciding with commit sees the old word.
      io_rd_addr = 6'd44;
      start_frame();
      load_words(32'h2000_0000, NW, 1'b0);
      exp_q.push_back(frame_bus(32'h2000_0000));
      send_word(frame_csum(32'h2000_0000), 1'b0);
      io_d_valid = 1'b0;
      tick();
      chk("rd_precommit", io_rd_data, 32'h1000_002C);
      tick();
      chk("rd_postcommit", io_rd_data, 32'h2000_002C);
      live_model = frame_bus(32'h2000_0000);

      // Reset while in CHECK clears everything, including the live bus.
      io_rd_addr = 6'd0;
      start_frame();
      load_words(32'h3000_0000, NW, 1'b0);
      chk("in_check_busy", io_busy, 1);
      chk("pre_rst_rd", io_rd_data, 32'h2000_0000);
      reset = 1'b1; io_d_valid = 1'b1; io_d_in = frame_csum(32'h3000_0000);
      tick();
      reset = 1'b0; io_d_valid = 1'b0;
      live_model = '0;
      chk("crst_busy", io_busy, 0);
      chk("crst_ready", io_d_ready, 0);
      chk("crst_done", io_done, 0);
      chk("crst_err", io_err, 0);
      chk("crst_rd", io_rd_data, 0);
      for (int i = 0; i < NW; i += 11)
         chk($sformatf("crst_live%0d", i), io_configs_out[WORD_W*i +: WORD_W], live_model[WORD_W*i +: WORD_W]);
      tick(); tick();
      chk("crst_no_done", io_done, 0);

      chk("pending_frames", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
